// File: rtl/dmem_responder.sv
// Wait-state data memory responder: one request at a time, valid/ready on both sides.
// Optional wait-state insertion is compiled in with DMEM_RESPONDER_WAIT_EN.
module dmem_responder #(
    parameter int DATA_WIDTH  = 16,
    parameter int ADDR_WIDTH  = 8,
    parameter int WAIT_CYCLES = 2
) (
    input  logic                  clk_i,
    input  logic                  rst_n_i,
    input  logic                  req_valid_i,
    output logic                  req_ready_o,
    input  logic                  req_we_i,
    input  logic [ADDR_WIDTH-1:0] req_addr_i,
    input  logic [DATA_WIDTH-1:0] req_wdata_i,
    output logic                  rsp_valid_o,
    input  logic                  rsp_ready_i,
    output logic [DATA_WIDTH-1:0] rsp_rdata_o
);

    localparam int DEPTH = 2 ** ADDR_WIDTH;

`ifdef DMEM_RESPONDER_WAIT_EN
    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_WAIT   = 2'd1,
        S_ACCESS = 2'd2,
        S_RESP   = 2'd3
    } state_t;

    localparam logic [3:0] WAIT_INIT = 4'(WAIT_CYCLES);
    logic [3:0] cnt_r;
`else
    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ACCESS = 2'd2,
        S_RESP   = 2'd3
    } state_t;

    // Wait states are not built in this configuration; the parameter is deliberately unused.
    localparam logic [3:0] WAIT_IGNORED = 4'(WAIT_CYCLES);
    logic unused_wait_s;
    assign unused_wait_s = ^WAIT_IGNORED;
`endif

    state_t                  state_r;
    logic                    req_ready_r;
    logic                    rsp_valid_r;
    logic [DATA_WIDTH-1:0]   rsp_rdata_r;
    logic                    we_r;
    logic [ADDR_WIDTH-1:0]   addr_r;
    logic [DATA_WIDTH-1:0]   wdata_r;
    logic [DATA_WIDTH-1:0]   mem_r [DEPTH];
    logic [DATA_WIDTH-1:0]   mem_rdata_s;

    assign mem_rdata_s = mem_r[addr_r];

    // Request/response sequencing; all outputs and captured fields are registered here.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_r     <= S_IDLE;
            req_ready_r <= 1'b0;
            rsp_valid_r <= 1'b0;
            rsp_rdata_r <= {DATA_WIDTH{1'b0}};
            we_r        <= 1'b0;
            addr_r      <= {ADDR_WIDTH{1'b0}};
            wdata_r     <= {DATA_WIDTH{1'b0}};
`ifdef DMEM_RESPONDER_WAIT_EN
            cnt_r       <= 4'd0;
`endif
        end else begin
            case (state_r)
                S_IDLE: begin
                    if (req_valid_i && req_ready_r) begin
                        req_ready_r <= 1'b0;
                        we_r        <= req_we_i;
                        addr_r      <= req_addr_i;
                        wdata_r     <= req_wdata_i;
`ifdef DMEM_RESPONDER_WAIT_EN
                        if (WAIT_INIT == 4'd0) begin
                            state_r <= S_ACCESS;
                        end else begin
                            state_r <= S_WAIT;
                            cnt_r   <= WAIT_INIT;
                        end
`else
                        state_r     <= S_ACCESS;
`endif
                    end else begin
                        // Ready comes up one edge after reset release and stays up while idle.
                        req_ready_r <= 1'b1;
                    end
                end
`ifdef DMEM_RESPONDER_WAIT_EN
                S_WAIT: begin
                    cnt_r <= cnt_r - 4'd1;
                    if (cnt_r == 4'd1) begin
                        state_r <= S_ACCESS;
                    end else begin
                        state_r <= S_WAIT;
                    end
                end
`endif
                S_ACCESS: begin
                    rsp_valid_r <= 1'b1;
                    rsp_rdata_r <= we_r ? wdata_r : mem_rdata_s;
                    state_r     <= S_RESP;
                end
                S_RESP: begin
                    if (rsp_ready_i) begin
                        rsp_valid_r <= 1'b0;
                        req_ready_r <= 1'b1;
                        state_r     <= S_IDLE;
                    end else begin
                        state_r     <= S_RESP;
                    end
                end
                default: begin
                    state_r     <= S_IDLE;
                    req_ready_r <= 1'b0;
                    rsp_valid_r <= 1'b0;
                end
            endcase
        end
    end

    // Storage array, intentionally not reset; written only during a store's ACCESS cycle.
    always_ff @(posedge clk_i) begin
        if ((state_r == S_ACCESS) && we_r) begin
            mem_r[addr_r] <= wdata_r;
        end
    end

    assign req_ready_o = req_ready_r;
    assign rsp_valid_o = rsp_valid_r;
    assign rsp_rdata_o = rsp_rdata_r;

endmodule

// File: tb/tb_dmem_responder.sv
// Directed self-checking bench for dmem_responder (default build or DMEM_RESPONDER_WAIT_EN).
module tb_dmem_responder;

`ifdef DMEM_RESPONDER_WAIT_EN
    localparam int WC  = 2;
    localparam int LAT = WC + 1;
`else
    localparam int WC  = 5;
    localparam int LAT = 1;
`endif

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [7:0]  req_addr;
    logic [15:0] req_wdata;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [15:0] rsp_rdata;

    int n_checks = 0;
    int n_errors = 0;
    int wait_n;

    always #5 clk = ~clk;

    dmem_responder #(
        .DATA_WIDTH (16),
        .ADDR_WIDTH (8),
        .WAIT_CYCLES(WC)
    ) dut (
        .clk_i      (clk),
        .rst_n_i    (rst_n),
        .req_valid_i(req_valid),
        .req_ready_o(req_ready),
        .req_we_i   (req_we),
        .req_addr_i (req_addr),
        .req_wdata_i(req_wdata),
        .rsp_valid_o(rsp_valid),
        .rsp_ready_i(rsp_ready),
        .rsp_rdata_o(rsp_rdata)
    );

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_checks++;
        if (obs !== exp_v) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp_v);
        end
    endtask

    // One full transaction: handshake, latency, data, optional back-pressure, return to idle.
    task automatic do_txn(input logic we, input logic [7:0] addr, input logic [15:0] wdata,
                          input int hold, input logic busy_valid, input logic [7:0] busy_addr,
                          input logic [15:0] exp_rdata, input string tag);
        int n;
        logic [15:0] held;
        @(negedge clk);
        req_valid = 1'b1;
        req_we    = we;
        req_addr  = addr;
        req_wdata = wdata;
        rsp_ready = 1'b0;
        n = 0;
        while (req_ready !== 1'b1 && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (n >= 50) begin
            check_eq({tag, "_accept_timeout"}, 32'd0, 32'd1);
            req_valid = 1'b0;
            return;
        end
        @(posedge clk);
        #1;
        if (busy_valid) begin
            req_we    = 1'b1;
            req_addr  = busy_addr;
            req_wdata = 16'hDEAD;
        end else begin
            req_valid = 1'b0;
            req_we    = ~we;
            req_addr  = ~addr;
            req_wdata = ~wdata;
        end
        n = 0;
        while (rsp_valid !== 1'b1 && n < 40) begin
            if (busy_valid) check_eq({tag, "_busy_ready"}, 32'(req_ready), 32'd0);
            @(posedge clk);
            #1;
            n++;
        end
        check_eq({tag, "_latency"}, 32'(n), 32'(LAT));
        check_eq({tag, "_rdata"}, 32'(rsp_rdata), 32'(exp_rdata));
        held = rsp_rdata;
        for (int i = 0; i < hold; i++) begin
            @(posedge clk);
            #1;
            check_eq({tag, "_hold_valid"}, 32'(rsp_valid), 32'd1);
            check_eq({tag, "_hold_rdata"}, 32'(rsp_rdata), 32'(held));
        end
        rsp_ready = 1'b1;
        @(posedge clk);
        #1;
        rsp_ready = 1'b0;
        req_valid = 1'b0;
        check_eq({tag, "_done_valid"}, 32'(rsp_valid), 32'd0);
        check_eq({tag, "_done_ready"}, 32'(req_ready), 32'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        rst_n     = 1'b0;
        req_valid = 1'b0;
        req_we    = 1'b0;
        req_addr  = 8'h00;
        req_wdata = 16'h0000;
        rsp_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check_eq("rst_req_ready", 32'(req_ready), 32'd0);
        check_eq("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        check_eq("rst_rsp_rdata", 32'(rsp_rdata), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check_eq("post_rst_ready_low", 32'(req_ready), 32'd0);
        @(posedge clk);
        #1;
        check_eq("post_rst_ready_high", 32'(req_ready), 32'd1);

        // Store then back-to-back load, then a load under back-pressure.
        do_txn(1'b1, 8'h10, 16'hBEEF, 0, 1'b0, 8'h00, 16'hBEEF, "st_beef");
        do_txn(1'b0, 8'h10, 16'h0000, 0, 1'b0, 8'h00, 16'hBEEF, "ld_beef");
        do_txn(1'b0, 8'h10, 16'h0000, 4, 1'b0, 8'h00, 16'hBEEF, "ld_hold");

        // Valid held high with another address while busy must be ignored.
        do_txn(1'b1, 8'h30, 16'h1111, 0, 1'b0, 8'h00, 16'h1111, "st_30");
        do_txn(1'b1, 8'h31, 16'h2222, 0, 1'b1, 8'h30, 16'h2222, "st_31_busy");
        do_txn(1'b0, 8'h30, 16'h0000, 0, 1'b0, 8'h00, 16'h1111, "ld_30");
        do_txn(1'b0, 8'h31, 16'h0000, 0, 1'b0, 8'h00, 16'h2222, "ld_31");

        // A store abandoned by reset must leave memory untouched.
        do_txn(1'b1, 8'h20, 16'h1234, 0, 1'b0, 8'h00, 16'h1234, "st_20");
        @(negedge clk);
        req_valid = 1'b1;
        req_we    = 1'b1;
        req_addr  = 8'h20;
        req_wdata = 16'hAAAA;
        wait_n = 0;
        while (req_ready !== 1'b1 && wait_n < 50) begin
            @(negedge clk);
            wait_n++;
        end
        check_eq("abort_accept", 32'(req_ready), 32'd1);
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        rst_n     = 1'b0;
        #1;
        check_eq("abort_rst_ready", 32'(req_ready), 32'd0);
        check_eq("abort_rst_valid", 32'(rsp_valid), 32'd0);
        check_eq("abort_rst_rdata", 32'(rsp_rdata), 32'd0);
        @(posedge clk);
        #1;
        check_eq("abort_rst_ready2", 32'(req_ready), 32'd0);
        check_eq("abort_rst_valid2", 32'(rsp_valid), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check_eq("abort_ready_rise", 32'(req_ready), 32'd1);
        do_txn(1'b0, 8'h20, 16'h0000, 0, 1'b0, 8'h00, 16'h1234, "ld_20");

        // Address range extremes.
        do_txn(1'b1, 8'h00, 16'h0001, 0, 1'b0, 8'h00, 16'h0001, "st_00");
        do_txn(1'b1, 8'hFF, 16'h5A5A, 0, 1'b0, 8'h00, 16'h5A5A, "st_ff");
        do_txn(1'b0, 8'hFF, 16'h0000, 0, 1'b0, 8'h00, 16'h5A5A, "ld_ff");
        do_txn(1'b0, 8'h00, 16'h0000, 0, 1'b0, 8'h00, 16'h0001, "ld_00");
        do_txn(1'b0, 8'h10, 16'h0000, 0, 1'b0, 8'h00, 16'hBEEF, "ld_10_again");

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/dmem_responder.md
DMEM_RESPONDER -- requirements
Module: dmem_responder

Interface
REQ-001 The block SHALL have parameter DATA_WIDTH, default 16, meaning data word width in bits.
REQ-002 The block SHALL have parameter ADDR_WIDTH, default 8, meaning word address width; memory depth is 2**ADDR_WIDTH words.
REQ-003 The block SHALL have parameter WAIT_CYCLES, default 2, meaning wait states inserted before each access (0..15).
REQ-004 The block SHALL have ports: clk_i  in  1  clock; one clock domain, all logic on the rising edge.
REQ-005 The block SHALL have port rst_n_i  in  1  reset; asynchronous, active-low.
REQ-006 The block SHALL have ports: req_valid_i  in  1  request valid; req_ready_o  out  1  request accepted when high with valid.
REQ-007 The block SHALL have ports: req_we_i  in  1  1=store, 0=load; req_addr_i  in  ADDR_WIDTH  word address; req_wdata_i  in  DATA_WIDTH  store data.
REQ-008 The block SHALL have ports: rsp_valid_o  out  1  response valid; rsp_ready_i  in  1  response consumed; rsp_rdata_o  out  DATA_WIDTH  load data, or echoed store data.

Function
REQ-009 The FSM SHALL have states IDLE, WAIT, ACCESS and RESP; req_ready_o SHALL be high only in IDLE.
REQ-010 A handshake (req_valid_i && req_ready_o) at edge T0 SHALL capture we/addr/wdata into internal registers and enter WAIT with counter=WAIT_CYCLES, or ACCESS directly if WAIT_CYCLES==0.
REQ-011 In WAIT the counter SHALL decrement once per cycle; at counter==1 the next state SHALL be ACCESS.
REQ-012 ACCESS SHALL last one cycle: a store writes mem[addr]<=wdata and loads rsp_rdata_o with wdata; a load loads rsp_rdata_o with mem[addr]. The next state SHALL be RESP.
REQ-013 rsp_valid_o SHALL rise at edge T0+WAIT_CYCLES+1 (latency WAIT_CYCLES+1 cycles) and SHALL be high only in RESP.
REQ-014 In RESP, rsp_valid_o and rsp_rdata_o SHALL hold stable until rsp_ready_i is sampled high; that edge SHALL return to IDLE.
REQ-015 The block SHALL accept no new request before returning to IDLE; minimum request spacing is WAIT_CYCLES+3 cycles. Inputs outside a handshake SHALL be ignored.
REQ-016 Captured request fields SHALL NOT change while the FSM is outside IDLE, regardless of input activity.
REQ-017 All 2**ADDR_WIDTH addresses SHALL be valid; address 2**ADDR_WIDTH-1 SHALL behave like any other, with no wrap or aliasing.
REQ-018 A load from an address stored earlier SHALL return the most recent stored value, including when the accesses are back-to-back.

Reset
REQ-019 While rst_n_i is low: state=IDLE, counter=0, rsp_valid_o=0, rsp_rdata_o=0, and req_ready_o=0.
REQ-020 req_ready_o SHALL rise in the first cycle after reset deasserts.
REQ-021 Memory array contents SHALL NOT be reset.
REQ-022 Reset asserted in WAIT or RESP SHALL abandon the transaction; a store still in WAIT SHALL NOT modify memory.

Configuration
REQ-023 With macro DMEM_RESPONDER_WAIT_EN defined, WAIT state and counter SHALL be compiled in, behaving per REQ-010..013.
REQ-024 Without DMEM_RESPONDER_WAIT_EN, the WAIT state and counter SHALL be absent, WAIT_CYCLES SHALL be ignored, handshake SHALL go directly to ACCESS, and latency SHALL be 1 cycle.

Verification
REQ-025 Store 0xBEEF at 0x10, then load 0x10 (WAIT_CYCLES=2, macro on) -> each rsp_valid_o 3 cycles after handshake; load rsp_rdata_o=0xBEEF.
REQ-026 Load with rsp_ready_i held low 4 cycles -> rsp_valid_o=1 and rsp_rdata_o stable all 4 cycles; IDLE one edge after rsp_ready_i=1.
REQ-027 req_valid_i held high with a different address during WAIT -> req_ready_o=0; second request accepted only after return to IDLE; data from the first address unaffected.
REQ-028 Store 0x1234 at 0x20, then store 0xAAAA at 0x20 with rst_n_i pulsed low during WAIT -> load 0x20 returns 0x1234; all outputs 0 during reset.
REQ-029 Store/load 0x5A5A at address 0xFF, load 0x00 previously holding 0x0001 -> 0x5A5A and 0x0001 respectively.
REQ-030 Macro undefined, WAIT_CYCLES=5 -> rsp_valid_o 1 cycle after every handshake.
